// File: rtl/elevator_pkg.sv
// Shared definitions for the three-floor elevator scheduler: floor codes,
// scheduler states and the default door dwell length.
package elevator_pkg;

  localparam logic [1:0] FLOOR_1       = 2'b00;
  localparam logic [1:0] FLOOR_2       = 2'b01;
  localparam logic [1:0] FLOOR_3       = 2'b10;
  localparam logic [1:0] FLOOR_INVALID = 2'b11;

  localparam int DOOR_HOLD_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UP,
    ST_DOWN,
    ST_HOLD,
    ST_SOS
  } state_e;

endpackage

// File: rtl/scan_goal_select.sv
// Combinational SCAN helper: finds the nearest pending request above and below
// the car and decides which way a fresh sweep should start.
module scan_goal_select
  import elevator_pkg::*;
#(
  parameter logic [1:0] labelF1 = FLOOR_1,
  parameter logic [1:0] labelF2 = FLOOR_2,
  parameter logic [1:0] labelF3 = FLOOR_3
) (
  input  logic [3:1] req,
  input  logic [1:0] floor,
  input  logic       dir_up,
  output logic       any_above,
  output logic       any_below,
  output logic [1:0] nearest_above,
  output logic [1:0] nearest_below,
  output logic       go_up
);

  localparam logic [3:1][1:0] LABELS = {labelF3, labelF2, labelF1};

  // Labels may be arbitrary codes, so nearest is a min/max search, not an index walk.
  always_comb begin
    any_above     = 1'b0;
    any_below     = 1'b0;
    nearest_above = floor;
    nearest_below = floor;
    for (int i = 1; i <= 3; i++) begin
      if (req[i] && (LABELS[i] > floor) && (!any_above || (LABELS[i] < nearest_above))) begin
        nearest_above = LABELS[i];
        any_above     = 1'b1;
      end
      if (req[i] && (LABELS[i] < floor) && (!any_below || (LABELS[i] > nearest_below))) begin
        nearest_below = LABELS[i];
        any_below     = 1'b1;
      end
    end
  end

  // Keep the current sweep direction unless there is nothing ahead in it.
  assign go_up = any_above && (dir_up || !any_below);

endmodule

// File: rtl/elevator_scheduler.sv
// Request latch, SCAN sequencer and door dwell timer for the three-floor car.
// Produces the goal floor for the movement datapath; every output is a flop.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int         DOOR_HOLD_CYCLES = DOOR_HOLD_DEFAULT,
  parameter logic [1:0] labelF1          = FLOOR_1,
  parameter logic [1:0] labelF2          = FLOOR_2,
  parameter logic [1:0] labelF3          = FLOOR_3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic [1:0] floor,
  input  logic       sos_mode,
  input  logic       weight_limit_exceeded,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic [1:0] goal_floor,
  output logic       goal_valid,
  output logic       dir_up,
  output logic       door_open
);

  localparam int              CNT_W  = $clog2(DOOR_HOLD_CYCLES + 1);
  localparam logic [3:1][1:0] LABELS = {labelF3, labelF2, labelF1};

  state_e             state_reg, state_next;
  logic [3:1]         req_reg, req_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [1:0]         goal_floor_reg, goal_floor_next;
  logic               goal_valid_reg, goal_valid_next;
  logic               dir_up_reg, dir_up_next;
  logic               door_open_reg, door_open_next;

  logic [3:1] btn;
  logic [3:1] at_floor;
  logic       floor_valid, here_btn, here_req, hold_like;
  logic       any_above, any_below, go_up;
  logic [1:0] nearest_above, nearest_below;

  assign btn = {button3, button2, button1};

  for (genvar gi = 1; gi <= 3; gi++) begin : g_at_floor
    assign at_floor[gi] = (floor == LABELS[gi]);
  end

  assign floor_valid = (floor != FLOOR_INVALID);
  assign here_btn    = |(btn & at_floor);
  assign here_req    = |(req_reg & at_floor);
  assign hold_like   = (state_reg == ST_IDLE) || (state_reg == ST_HOLD);

  scan_goal_select #(
    .labelF1(labelF1),
    .labelF2(labelF2),
    .labelF3(labelF3)
  ) u_scan (
    .req          (req_reg),
    .floor        (floor),
    .dir_up       (dir_up_reg),
    .any_above    (any_above),
    .any_below    (any_below),
    .nearest_above(nearest_above),
    .nearest_below(nearest_below),
    .go_up        (go_up)
  );

  always_comb begin
    state_next      = state_reg;
    req_next        = req_reg;
    cnt_next        = cnt_reg;
    goal_floor_next = goal_floor_reg;
    goal_valid_next = 1'b0;
    dir_up_next     = dir_up_reg;
    door_open_next  = 1'b0;

    // A press at the floor where the car is parked/dwelling reopens the door instead of latching.
    for (int i = 1; i <= 3; i++) begin
      if (btn[i] && !(hold_like && at_floor[i])) req_next[i] = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (floor_valid) begin
          if (here_btn || here_req) begin
            state_next     = ST_HOLD;
            req_next       = req_next & ~at_floor;
            cnt_next       = CNT_W'(DOOR_HOLD_CYCLES);
            door_open_next = 1'b1;
          end else if (go_up) begin
            state_next      = ST_UP;
            dir_up_next     = 1'b1;
            goal_floor_next = nearest_above;
            goal_valid_next = 1'b1;
          end else if (any_below) begin
            state_next      = ST_DOWN;
            dir_up_next     = 1'b0;
            goal_floor_next = nearest_below;
            goal_valid_next = 1'b1;
          end
        end
      end
      ST_UP, ST_DOWN: begin
        if (!floor_valid) begin
          state_next = ST_IDLE;
        end else if (floor == goal_floor_reg) begin
          state_next     = ST_HOLD;
          req_next       = req_next & ~at_floor;
          cnt_next       = CNT_W'(DOOR_HOLD_CYCLES);
          door_open_next = 1'b1;
        end else if ((state_reg == ST_UP) && any_above) begin
          goal_floor_next = nearest_above;
          goal_valid_next = 1'b1;
        end else if ((state_reg == ST_DOWN) && any_below) begin
          goal_floor_next = nearest_below;
          goal_valid_next = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!floor_valid) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (here_btn) begin
          cnt_next       = CNT_W'(DOOR_HOLD_CYCLES);
          door_open_next = 1'b1;
        end else if (weight_limit_exceeded) begin
          door_open_next = 1'b1;
        end else if (cnt_reg <= CNT_W'(1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next       = cnt_reg - CNT_W'(1);
          door_open_next = 1'b1;
        end
      end
      ST_SOS: begin
        req_next = '0;
        if (!sos_mode) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Emergency stop outranks every other decision taken above.
    if (sos_mode) begin
      state_next      = ST_SOS;
      req_next        = '0;
      cnt_next        = '0;
      goal_valid_next = 1'b0;
      door_open_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      req_reg        <= '0;
      cnt_reg        <= '0;
      goal_floor_reg <= labelF1;
      goal_valid_reg <= 1'b0;
      dir_up_reg     <= 1'b1;
      door_open_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      req_reg        <= req_next;
      cnt_reg        <= cnt_next;
      goal_floor_reg <= goal_floor_next;
      goal_valid_reg <= goal_valid_next;
      dir_up_reg     <= dir_up_next;
      door_open_reg  <= door_open_next;
    end
  end

  assign led1       = req_reg[1];
  assign led2       = req_reg[2];
  assign led3       = req_reg[3];
  assign goal_floor = goal_floor_reg;
  assign goal_valid = goal_valid_reg;
  assign dir_up     = dir_up_reg;
  assign door_open  = door_open_reg;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: walks the car through sweeps, dwells,
// overload, SOS and invalid floor codes against hand-computed expectations.
module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       button1, button2, button3;
  logic [1:0] floor;
  logic       sos_mode, weight_limit_exceeded;
  logic       led1, led2, led3;
  logic [1:0] goal_floor;
  logic       goal_valid, dir_up, door_open;

  int check_cnt = 0;
  int pass_cnt  = 0;

  elevator_scheduler #(
    .DOOR_HOLD_CYCLES(4),
    .labelF1(2'b00),
    .labelF2(2'b01),
    .labelF3(2'b10)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .button1              (button1),
    .button2              (button2),
    .button3              (button3),
    .floor                (floor),
    .sos_mode             (sos_mode),
    .weight_limit_exceeded(weight_limit_exceeded),
    .led1                 (led1),
    .led2                 (led2),
    .led3                 (led3),
    .goal_floor           (goal_floor),
    .goal_valid           (goal_valid),
    .dir_up               (dir_up),
    .door_open            (door_open)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("chk %-16s got=%0h exp=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-16s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_door_low();
    int n;
    n = 0;
    while (door_open && n < 40) begin
      step();
      n++;
    end
    check_val("door_low", {31'b0, door_open}, 32'd0);
  endtask

  int len, vseen, n;

  initial begin
    reset = 1'b1; button1 = 1'b0; button2 = 1'b0; button3 = 1'b0;
    floor = 2'b00; sos_mode = 1'b0; weight_limit_exceeded = 1'b0;
    step(); step();
    reset = 1'b0;
    check_val("rst_leds", {29'b0, led3, led2, led1}, 32'd0);
    check_val("rst_goal", {30'b0, goal_floor}, 32'd0);
    check_val("rst_valid", {31'b0, goal_valid}, 32'd0);
    check_val("rst_dir", {31'b0, dir_up}, 32'd1);
    check_val("rst_door", {31'b0, door_open}, 32'd0);

    // Call to floor 3 from floor 1
    button3 = 1'b1; step(); button3 = 1'b0;
    check_val("led3_set", {31'b0, led3}, 32'd1);
    check_val("valid_lat", {31'b0, goal_valid}, 32'd0);
    step();
    check_val("goal_f3", {30'b0, goal_floor}, 32'h2);
    check_val("goal_valid", {31'b0, goal_valid}, 32'd1);
    check_val("dir_up", {31'b0, dir_up}, 32'd1);

    // Intermediate call retargets, dwell of 4 cycles
    button2 = 1'b1; step(); button2 = 1'b0;
    check_val("led2_set", {31'b0, led2}, 32'd1);
    step();
    check_val("retarget_f2", {30'b0, goal_floor}, 32'h1);
    floor = 2'b01; step();
    check_val("arr_door", {31'b0, door_open}, 32'd1);
    check_val("arr_valid", {31'b0, goal_valid}, 32'd0);
    check_val("led2_clr", {31'b0, led2}, 32'd0);
    len = 0; vseen = 0; n = 0;
    while (door_open && n < 40) begin
      len++;
      if (goal_valid) vseen = 1;
      step();
      n++;
    end
    check_val("dwell_len", len, 32'd4);
    check_val("dwell_noval", vseen, 32'd0);
    step();
    check_val("resume_f3", {30'b0, goal_floor}, 32'h2);
    check_val("resume_val", {31'b0, goal_valid}, 32'd1);

    // Overload for 3 cycles stretches dwell to 7
    floor = 2'b10; step();
    check_val("arr3_door", {31'b0, door_open}, 32'd1);
    weight_limit_exceeded = 1'b1;
    len = 0; vseen = 0; n = 0;
    while (door_open && n < 40) begin
      len++;
      if (goal_valid) vseen = 1;
      step();
      n++;
      if (n == 3) weight_limit_exceeded = 1'b0;
    end
    weight_limit_exceeded = 1'b0;
    check_val("ovl_dwell_len", len, 32'd7);
    check_val("ovl_noval", vseen, 32'd0);
    step();
    check_val("idle_noval", {31'b0, goal_valid}, 32'd0);

    // Sweep down, stop at floor 2, direction kept down with calls both sides
    button1 = 1'b1; step(); button1 = 1'b0;
    step();
    check_val("down_goal", {30'b0, goal_floor}, 32'h0);
    check_val("down_dir", {31'b0, dir_up}, 32'd0);
    button2 = 1'b1; step(); button2 = 1'b0;
    step();
    check_val("down_retgt", {30'b0, goal_floor}, 32'h1);
    floor = 2'b01; step();
    check_val("f2_door", {31'b0, door_open}, 32'd1);
    button3 = 1'b1; step(); button3 = 1'b0;
    wait_door_low();
    step();
    check_val("scan_goal", {30'b0, goal_floor}, 32'h0);
    check_val("scan_dir", {31'b0, dir_up}, 32'd0);
    check_val("scan_leds", {29'b0, led3, led2, led1}, 32'b101);
    floor = 2'b00; step();
    check_val("f1_door", {31'b0, door_open}, 32'd1);
    wait_door_low();
    step();
    check_val("then_f3", {30'b0, goal_floor}, 32'h2);
    check_val("then_dir", {31'b0, dir_up}, 32'd1);

    // SOS while moving with requests pending
    button2 = 1'b1; step(); button2 = 1'b0;
    check_val("pre_sos_leds", {29'b0, led3, led2, led1}, 32'b110);
    sos_mode = 1'b1; step();
    check_val("sos_leds", {29'b0, led3, led2, led1}, 32'd0);
    check_val("sos_valid", {31'b0, goal_valid}, 32'd0);
    check_val("sos_door", {31'b0, door_open}, 32'd0);
    button1 = 1'b1; step(); button1 = 1'b0;
    check_val("sos_ignore", {29'b0, led3, led2, led1}, 32'd0);
    sos_mode = 1'b0; step(); step();
    check_val("post_sos", {31'b0, goal_valid}, 32'd0);

    // Invalid floor code while moving up
    button3 = 1'b1; step(); button3 = 1'b0;
    step();
    check_val("inv_pre_val", {31'b0, goal_valid}, 32'd1);
    floor = 2'b11; step();
    check_val("inv_valid", {31'b0, goal_valid}, 32'd0);
    check_val("inv_keep_led", {31'b0, led3}, 32'd1);
    step();
    check_val("inv_stay", {31'b0, goal_valid}, 32'd0);
    floor = 2'b01; step();
    check_val("inv_rest_val", {31'b0, goal_valid}, 32'd1);
    check_val("inv_rest_goal", {30'b0, goal_floor}, 32'h2);

    // Button at the parked floor opens the door without latching
    floor = 2'b10; step();
    wait_door_low();
    button3 = 1'b1; step(); button3 = 1'b0;
    check_val("here_door", {31'b0, door_open}, 32'd1);
    check_val("here_noled", {31'b0, led3}, 32'd0);
    wait_door_low();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler and sequencer for the three-floor car. It latches floor requests from the buttons and drives the request LEDs. It selects the next goal floor with a SCAN (keep-direction) policy and holds the door open for a fixed dwell after each arrival. It sits above the movement datapath: it supplies `goal_floor`/`goal_valid` and consumes the car's current floor code, `sos_mode` and `weight_limit_exceeded`.

## Interface
Parameters:
- `DOOR_HOLD_CYCLES`, default 4: number of cycles `door_open` stays high per served stop (must be ≥ 1).
- `labelF1`, default 2'b00: floor 1 code.
- `labelF2`, default 2'b01: floor 2 code.
- `labelF3`, default 2'b10: floor 3 code.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `button1`/`button2`/`button3`  in  1 each  request for floor 1/2/3 (level; sampled every cycle).
- `floor`  in  2  current car floor code; 2'b11 is invalid.
- `sos_mode`  in  1  emergency stop; overrides everything.
- `weight_limit_exceeded`  in  1  overload; freezes door dwell.
- `led1`/`led2`/`led3`  out  1 each  pending-request indicator per floor (registered).
- `goal_floor`  out  2  floor code the car must travel to.
- `goal_valid`  out  1  `goal_floor` is meaningful and the car should move.
- `dir_up`  out  1  current sweep direction (1 = up).
- `door_open`  out  1  door dwell active at current floor.

## Operation
- States: IDLE, UP, DOWN, HOLD, SOS.
- Request latch `req[3:1]` drives `led1..3` directly.
  - Set when the button is high.
  - Cleared on entry to HOLD at that floor.
  - Button for the current floor while in IDLE or HOLD: no latch; the FSM enters or re-enters HOLD and the dwell counter reloads.
- IDLE, with requests pending:
  - Go UP when a request exists above `floor` and (`dir_up` = 1 or no request exists below).
  - Otherwise go DOWN.
  - `dir_up` is updated to match the chosen direction.
- IDLE with no requests: stay in IDLE; `goal_valid` = 0.
- UP/DOWN:
  - Each cycle, `goal_floor` = nearest pending request in the sweep direction, and `goal_valid` = 1.
  - When `floor == goal_floor`: enter HOLD, clear that `req` bit, load the counter with `DOOR_HOLD_CYCLES`.
- A new request between the car and its goal, in the sweep direction, retargets `goal_floor` the next cycle.
- HOLD:
  - `door_open` = 1 and `goal_valid` = 0.
  - The counter decrements each cycle unless `weight_limit_exceeded` = 1, in which case it holds.
  - When the counter reaches 1 and there is no overload, go to IDLE.
- SOS:
  - Entered from any state when `sos_mode` = 1.
  - Clears all `req` bits; `goal_valid` = 0, `door_open` = 0; buttons are ignored.
  - Exits to IDLE on the first cycle with `sos_mode` = 0.
- Invalid `floor` (2'b11): `goal_valid` = 0. UP/DOWN/HOLD drop to IDLE; IDLE stays put until the code is valid. Requests are retained.
- Floor codes are compared as unsigned values: above means strictly greater, below means strictly less.

## Timing
- Reset values: `led1..3` = 0, `goal_floor` = `labelF1`, `goal_valid` = 0, `dir_up` = 1, `door_open` = 0, state = IDLE, counter = 0.
- All outputs are registered.
- Button → LED: 1 cycle.
- Request latched in IDLE → `goal_valid` = 1: 1 further cycle, since IDLE evaluates registered `req`.
- Arrival (`floor == goal_floor` sampled) → `door_open` = 1 and `goal_valid` = 0: next cycle.
- `door_open` is high for exactly `DOOR_HOLD_CYCLES` cycles with no overload, extended by one cycle per overloaded cycle.
- HOLD → IDLE → UP/DOWN: at least 1 idle cycle between dwell end and next `goal_valid`.
- Simultaneous events: `sos_mode` beats reset-free logic and all requests; `reset` beats `sos_mode`. A button press in the same cycle as its clear lets the set win, unless the car is at that floor.

## Structure
- Shared package `elevator_pkg`:
  - Floor label constants.
  - State enum (IDLE/UP/DOWN/HOLD/SOS).
  - Default `DOOR_HOLD_CYCLES`.
- One sub-module, `scan_goal_select` (combinational). Inputs: `req`, `floor`, `dir_up`. Outputs: `any_above`, `any_below`, `nearest_above`, `nearest_below`.
- FSM, request latch and dwell counter live in `elevator_scheduler`.

## Test plan
- Reset, then `floor` = 00 and pulse `button3` → `led3` = 1 after 1 cycle; `goal_floor` = 10 and `dir_up` = 1 one cycle later.
- Car at 00 going to 10; press `button2`, then present `floor` = 01 → `goal_floor` retargets to 01; on arrival `door_open` is high 4 cycles, `led2` clears, then `goal_floor` = 10.
- In HOLD, assert `weight_limit_exceeded` for 3 cycles → `door_open` lasts 7 cycles; no `goal_valid` during the dwell.
- `floor` = 01 with `dir_up` = 0 and requests at 00 and 10 → DOWN first (`goal_floor` = 00), then 10 after the dwell.
- Requests pending while moving, assert `sos_mode` → next cycle all LEDs 0 and `goal_valid` = 0; buttons ignored; deassert → IDLE.
- `floor` = 11 while UP → `goal_valid` drops to 0 and requests are kept; valid floor restores the goal within 2 cycles.
